// File: rtl/mp_sram_1rw1r.sv
// mp_sram_1rw1r: two-port SRAM behavioural model sharing one clock.
// Port 0 reads and writes with a per-lane write mask; port 1 only reads.
// Inputs are registered and reads are combinational from the registered
// addresses. A captured write commits on the following edge, and only once.
// Optional feature macro: MP_SRAM_VALID_EN adds a per-word valid array with
// a one-cycle flush. Without it, valid0/valid1 read as 1 and flush is ignored.
module mp_sram_1rw1r #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int WMASK_WIDTH = 4
) (
  input  logic                   clk0,
  input  logic                   rst0,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  output logic                   valid0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   valid1,
  input  logic                   flush
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int LANE_W    = DATA_WIDTH / WMASK_WIDTH;

  logic [DATA_WIDTH-1:0]  mem [RAM_DEPTH];

  logic                   web0_q,   web0_d;
  logic [WMASK_WIDTH-1:0] wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0]  addr0_q,  addr0_d;
  logic [DATA_WIDTH-1:0]  din0_q,   din0_d;
  logic [ADDR_WIDTH-1:0]  addr1_q,  addr1_d;

  logic commit;

  // Port 0/1 capture: a deselected port 0 cancels any pending write but keeps
  // its address so dout0 keeps pointing at the same word.
  always_comb begin
    web0_d   = 1'b1;
    wmask0_d = wmask0_q;
    addr0_d  = addr0_q;
    din0_d   = din0_q;
    addr1_d  = addr1_q;
    if (!csb0) begin
      web0_d   = web0;
      wmask0_d = wmask0;
      addr0_d  = addr0;
      din0_d   = din0;
    end
    if (!csb1) begin
      addr1_d = addr1;
    end
  end

  // Input registers, asynchronously reset so an in-flight write is aborted.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      web0_q   <= 1'b1;
      wmask0_q <= '0;
      addr0_q  <= '0;
      din0_q   <= '0;
      addr1_q  <= '0;
    end else begin
      web0_q   <= web0_d;
      wmask0_q <= wmask0_d;
      addr0_q  <= addr0_d;
      din0_q   <= din0_d;
      addr1_q  <= addr1_d;
    end
  end

  // A commit happens on the edge after capture; web0_q is reloaded every
  // edge, so each capture produces exactly one commit.
  assign commit = !web0_q;

  // Array write: only masked lanes change; contents are never reset.
  always_ff @(posedge clk0) begin
    if (commit) begin
      for (int i = 0; i < WMASK_WIDTH; i++) begin
        if (wmask0_q[i]) begin
          mem[addr0_q][i*LANE_W +: LANE_W] <= din0_q[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign dout0 = mem[addr0_q];
  assign dout1 = mem[addr1_q];

`ifdef MP_SRAM_VALID_EN
  logic [RAM_DEPTH-1:0] valid_q;

  // Valid array: flush beats a same-edge commit; an all-zero mask leaves the
  // bit alone.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (commit && (|wmask0_q)) begin
      valid_q[addr0_q] <= 1'b1;
    end
  end

  assign valid0 = valid_q[addr0_q];
  assign valid1 = valid_q[addr1_q];
`else
  logic unused_flush;

  assign unused_flush = flush;
  assign valid0       = 1'b1;
  assign valid1       = 1'b1;
`endif

endmodule

// File: tb/tb_mp_sram_1rw1r.sv
// tb_mp_sram_1rw1r: directed-vector bench for mp_sram_1rw1r.
// Expected valid values follow MP_SRAM_VALID_EN.
`timescale 1ns/1ps
module tb_mp_sram_1rw1r;

  logic        clk0 = 1'b0;
  logic        rst0;
  logic        csb0;
  logic        web0;
  logic [3:0]  wmask0;
  logic [3:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;
  logic        valid0;
  logic        csb1;
  logic [3:0]  addr1;
  logic [31:0] dout1;
  logic        valid1;
  logic        flush;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MP_SRAM_VALID_EN
  localparam logic V_CLR = 1'b0;
`else
  localparam logic V_CLR = 1'b1;
`endif

  mp_sram_1rw1r #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4),
    .WMASK_WIDTH(4)
  ) dut (
    .clk0  (clk0),
    .rst0  (rst0),
    .csb0  (csb0),
    .web0  (web0),
    .wmask0(wmask0),
    .addr0 (addr0),
    .din0  (din0),
    .dout0 (dout0),
    .valid0(valid0),
    .csb1  (csb1),
    .addr1 (addr1),
    .dout1 (dout1),
    .valid1(valid1),
    .flush (flush)
  );

  always #5 clk0 = ~clk0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic p0_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
  endtask

  task automatic p0_read(input logic [3:0] a);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a; wmask0 = 4'h0;
  endtask

  initial begin
    rst0 = 1'b0; csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = 4'h0;
    din0 = 32'h0; csb1 = 1'b1; addr1 = 4'h0; flush = 1'b0;
    tick();

    // Reset then read: capture addr 3 on both ports, then reset mid-cycle.
    p0_read(4'd3); csb1 = 1'b0; addr1 = 4'd3;
    tick();
    chk("addr0_cap", 32'(dut.addr0_q), 32'd3);
    #2 rst0 = 1'b1;
    #1;
    chk("rst_addr0", 32'(dut.addr0_q), 32'd0);
    chk("rst_addr1", 32'(dut.addr1_q), 32'd0);
    chk("rst_web0",  32'(dut.web0_q),  32'd1);
    chk("rst_valid0", 32'(valid0), 32'(V_CLR));
    chk("rst_valid1", 32'(valid1), 32'(V_CLR));
    csb0 = 1'b1; csb1 = 1'b1;
    tick();
    rst0 = 1'b0;
    tick();

    // Masked write to addr 5.
    p0_write(4'd5, 32'hAABBCCDD, 4'hF);
    tick();
    p0_write(4'd5, 32'h11223344, 4'b0101);
    tick();
    chk("mask_first", dout0, 32'hAABBCCDD);
    p0_read(4'd5);
    tick();
    chk("mask_merge", dout0, 32'hAA22CC44);
    chk("mask_valid0", 32'(valid0), 32'd1);

    // Write then read on the same word from both ports.
    p0_write(4'd2, 32'h12345678, 4'hF);
    tick();
    p0_read(4'd0);
    tick();
    p0_write(4'd2, 32'hDEADBEEF, 4'hF); csb1 = 1'b0; addr1 = 4'd2;
    tick();
    chk("rdw_old_p1", dout1, 32'h12345678);
    p0_read(4'd2);
    tick();
    chk("rdw_new_p1", dout1, 32'hDEADBEEF);
    chk("rdw_new_p0", dout0, 32'hDEADBEEF);
    chk("rdw_valid1", 32'(valid1), 32'd1);

    // Single-shot write: port 0 deselected with changing inputs afterwards.
    p0_write(4'd7, 32'h00000001, 4'hF);
    tick();
    csb0 = 1'b1; web0 = 1'b0; din0 = 32'hFFFFFFFF; addr1 = 4'd7;
    tick();
    chk("ss_dout1_0", dout1, 32'h00000001);
    chk("ss_web0",    32'(dut.web0_q), 32'd1);
    din0 = 32'hA5A5A5A5;
    tick();
    chk("ss_dout1_1", dout1, 32'h00000001);
    chk("ss_mem_1",   dut.mem[7], 32'h00000001);
    din0 = 32'h5A5A5A5A; wmask0 = 4'hF;
    tick();
    chk("ss_dout1_2", dout1, 32'h00000001);
    chk("ss_mem_2",   dut.mem[7], 32'h00000001);

    // Flush on the same edge as a commit to addr 9.
    p0_write(4'd9, 32'h00000055, 4'hF);
    tick();
    csb0 = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_mem9",   dut.mem[9], 32'h00000055);
    chk("fl_dout0",  dout0, 32'h00000055);
    chk("fl_valid0", 32'(valid0), 32'(V_CLR));
    chk("fl_valid1", 32'(valid1), 32'(V_CLR));
    addr1 = 4'd5;
    tick();
    chk("fl_valid5", 32'(valid1), 32'(V_CLR));

    // Zero-mask write: no data change.
    p0_write(4'd5, 32'h0, 4'h0);
    tick();
    p0_read(4'd5);
    tick();
    chk("zm_data", dout0, 32'hAA22CC44);

    // Reset mid-write to addr 4.
    p0_write(4'd4, 32'h00001234, 4'hF);
    tick();
    p0_write(4'd4, 32'h000000FF, 4'hF);
    tick();
    csb0 = 1'b1;
    #2 rst0 = 1'b1;
    #1;
    chk("rmw_web0", 32'(dut.web0_q), 32'd1);
    tick();
    rst0 = 1'b0;
    tick();
    chk("rmw_mem4", dut.mem[4], 32'h00001234);
    p0_read(4'd4);
    tick();
    chk("rmw_dout0", dout0, 32'h00001234);
    chk("rmw_valid0", 32'(valid0), 32'(V_CLR));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
